// File: rtl/note_lane_pkg.sv
// Shared constants, slot record and lane geometry helper for the note scroller.
package note_lane_pkg;

  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_SLOTS      = 4;
  localparam int unsigned DEF_SCREEN_H   = 480;
  localparam int unsigned DEF_NOTE_W     = 50;
  localparam int unsigned DEF_SPEED      = 1;
  localparam int unsigned DEF_LANE_X0    = 170;
  localparam int unsigned DEF_LANE_PITCH = 100;
  localparam int unsigned DEF_HIT_Y      = 400;

  typedef struct packed {
    logic       valid;
    logic [9:0] y;
  } slot_t;

  function automatic int unsigned lane_x(input int unsigned l,
                                         input int unsigned x0    = DEF_LANE_X0,
                                         input int unsigned pitch = DEF_LANE_PITCH);
    return x0 + l * pitch;
  endfunction

endpackage

// File: rtl/note_lane.sv
// One fret lane: SLOTS falling-note registers with spawn, move/retire,
// strum judging and the per-lane pixel hit test.
module note_lane
  import note_lane_pkg::*;
#(
  parameter int unsigned SLOTS    = DEF_SLOTS,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned NOTE_W   = DEF_NOTE_W,
  parameter int unsigned SPEED    = DEF_SPEED,
  parameter int unsigned HIT_Y    = DEF_HIT_Y,
  parameter int unsigned X_LEFT   = DEF_LANE_X0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             spawn,
  input  logic             strum,
  input  logic [9:0]       x,
  input  logic [8:0]       y,
  output logic             free,
  output logic [SLOTS-1:0] valid,
  output logic             pixel,
  output logic             hit,
  output logic             miss
);

  slot_t            slots [SLOTS];
  slot_t            nxt   [SLOTS];
  logic [10:0]      sum   [SLOTS];
  logic [SLOTS-1:0] free_vec, free_one, win, match_one, hit_sel, exits;
  logic             in_x, pix_next;

  always_comb begin
    for (int unsigned s = 0; s < SLOTS; s++) begin
      valid[s] = slots[s].valid;
      win[s]   = slots[s].valid
               && ({1'b0, slots[s].y} >= 11'(HIT_Y))
               && ({1'b0, slots[s].y} <  11'(HIT_Y + NOTE_W));
    end
    free_vec  = ~valid;
    free_one  = free_vec & (~free_vec + SLOTS'(1));
    match_one = win & (~win + SLOTS'(1));
    hit_sel   = strum ? match_one : '0;
    free      = |free_vec;
  end

  // A slot taken by this cycle's strum is neither moved nor retired;
  // spawn only targets slots already free before any clear this cycle.
  always_comb begin
    for (int unsigned s = 0; s < SLOTS; s++) begin
      nxt[s]   = slots[s];
      exits[s] = 1'b0;
      sum[s]   = {1'b0, slots[s].y} + 11'(SPEED);
      if (slots[s].valid) begin
        if (hit_sel[s]) begin
          nxt[s].valid = 1'b0;
        end else if (frame_tick) begin
          if (sum[s] >= 11'(SCREEN_H)) begin
            nxt[s].valid = 1'b0;
            exits[s]     = 1'b1;
          end else begin
            nxt[s].y = sum[s][9:0];
          end
        end
      end else if (spawn && free_one[s]) begin
        nxt[s].valid = 1'b1;
        nxt[s].y     = '0;
      end
    end
  end

  always_comb begin
    in_x     = ({1'b0, x} >= 11'(X_LEFT)) && ({1'b0, x} < 11'(X_LEFT + NOTE_W));
    pix_next = 1'b0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (slots[s].valid && in_x
          && ({2'b00, y} >= {1'b0, slots[s].y})
          && ({2'b00, y} <  ({1'b0, slots[s].y} + 11'(NOTE_W))))
        pix_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        slots[s] <= '0;
      end
      pixel <= 1'b0;
      hit   <= 1'b0;
      miss  <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        slots[s] <= nxt[s];
      end
      pixel <= pix_next;
      hit   <= |hit_sel;
      miss  <= (|exits) | (strum & ~(|win));
    end
  end

endmodule

// File: rtl/note_lane_engine.sv
// Note scroller top: spawn handshake across lanes, lane array, live-note count.
module note_lane_engine
  import note_lane_pkg::*;
#(
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned SLOTS      = DEF_SLOTS,
  parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
  parameter int unsigned NOTE_W     = DEF_NOTE_W,
  parameter int unsigned SPEED      = DEF_SPEED,
  parameter int unsigned LANE_X0    = DEF_LANE_X0,
  parameter int unsigned LANE_PITCH = DEF_LANE_PITCH,
  parameter int unsigned HIT_Y      = DEF_HIT_Y
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               frame_tick,
  input  logic                               spawn_valid,
  input  logic [LANES-1:0]                   spawn_mask,
  output logic                               spawn_ready,
  input  logic [LANES-1:0]                   strum,
  input  logic [9:0]                         x,
  input  logic [8:0]                         y,
  output logic [LANES-1:0]                   pixel_in_note,
  output logic [LANES-1:0]                   hit,
  output logic [LANES-1:0]                   miss,
  output logic [$clog2(LANES*SLOTS+1)-1:0]   notes_live
);

  localparam int unsigned CW = $clog2(LANES*SLOTS+1);

  logic [LANES-1:0] lane_free;
  logic [SLOTS-1:0] lane_valid [LANES];
  logic             spawn_fire;
  logic [CW-1:0]    pop;

  assign spawn_ready = &(~spawn_mask | lane_free);
  assign spawn_fire  = spawn_valid & spawn_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_lane #(
      .SLOTS    (SLOTS),
      .SCREEN_H (SCREEN_H),
      .NOTE_W   (NOTE_W),
      .SPEED    (SPEED),
      .HIT_Y    (HIT_Y),
      .X_LEFT   (lane_x(l, LANE_X0, LANE_PITCH))
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .spawn      (spawn_fire & spawn_mask[l]),
      .strum      (strum[l]),
      .x          (x),
      .y          (y),
      .free       (lane_free[l]),
      .valid      (lane_valid[l]),
      .pixel      (pixel_in_note[l]),
      .hit        (hit[l]),
      .miss       (miss[l])
    );
  end

  always_comb begin
    pop = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        pop = pop + CW'(lane_valid[l][s]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) notes_live <= '0;
    else        notes_live <= pop;
  end

endmodule

// File: tb/tb_note_lane_engine.sv
// Scoreboarded directed bench for note_lane_engine with default geometry.
module tb_note_lane_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       spawn_valid = 1'b0;
  logic [3:0] spawn_mask = '0;
  logic       spawn_ready;
  logic [3:0] strum = '0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [3:0] pixel_in_note, hit, miss;
  logic [4:0] notes_live;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  note_lane_engine dut (
    .clk           (clk),
    .reset         (rst_n),
    .frame_tick    (frame_tick),
    .spawn_valid   (spawn_valid),
    .spawn_mask    (spawn_mask),
    .spawn_ready   (spawn_ready),
    .strum         (strum),
    .x             (x),
    .y             (y),
    .pixel_in_note (pixel_in_note),
    .hit           (hit),
    .miss          (miss),
    .notes_live    (notes_live)
  );

  always #5 clk = ~clk;

  // Event monitor: every hit/miss pulse must match the oldest expected event.
  always @(negedge clk) begin
    if ((hit | miss) != 4'b0000) begin
      logic [7:0] e;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL event: got hit=%b miss=%b, required no event", hit, miss);
      end else begin
        e = exp_q.pop_front();
        if ({hit, miss} !== e) begin
          mismatched++;
          $display("FAIL event: got hit=%b miss=%b, required hit=%b miss=%b",
                   hit, miss, e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    strum      = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spawn_valid = 1'b0; spawn_mask = '0; strum = '0; frame_tick = 1'b0;
    x = '0; y = '0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input logic [3:0] m);
    spawn_valid = 1'b1;
    spawn_mask  = m;
    cyc();
    spawn_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
    end
  endtask

  task automatic do_strum(input logic [3:0] m, input logic [3:0] eh, input logic [3:0] em);
    strum = m;
    exp_q.push_back({eh, em});
    cyc();
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    spawn_mask = 4'b1111; x = 10'd170; y = 9'd0;
    #13;
    chk("reset_ready", 8'(spawn_ready), 8'd1);
    chk("reset_pixel", 8'(pixel_in_note), 8'd0);
    chk("reset_hitmiss", {hit, miss}, 8'd0);
    chk("reset_live", 8'(notes_live), 8'd0);

    // Reset and spawn
    do_reset();
    do_spawn(4'b0101);
    chk("spawn_ready_after", 8'(spawn_ready), 8'd1);
    x = 10'd370; y = 9'd0;
    cyc();
    chk("spawn_live", 8'(notes_live), 8'd2);
    chk("spawn_pixel_lane2", 8'(pixel_in_note), 8'b0100);

    // Move and retire
    do_reset();
    do_spawn(4'b0001);
    ticks(479);
    chk("retire_live_before", 8'(notes_live), 8'd1);
    exp_q.push_back({4'b0000, 4'b0001});
    ticks(1);
    cyc(); cyc();
    chk("retire_live_after", 8'(notes_live), 8'd0);

    // Full lane and held spawn
    do_reset();
    for (int i = 0; i < 4; i++) do_spawn(4'b0001);
    spawn_mask = 4'b0001;
    #1 chk("full_ready_lane0", 8'(spawn_ready), 8'd0);
    spawn_mask = 4'b0010;
    #1 chk("full_ready_lane1", 8'(spawn_ready), 8'd1);
    spawn_mask = 4'b0001;
    spawn_valid = 1'b1;
    cyc(); cyc();
    chk("full_pending_live", 8'(notes_live), 8'd4);
    ticks(400);
    do_strum(4'b0001, 4'b0001, 4'b0000);
    chk("full_ready_freed", 8'(spawn_ready), 8'd1);
    cyc();
    spawn_valid = 1'b0;
    chk("full_live_mid", 8'(notes_live), 8'd3);
    chk("full_ready_again", 8'(spawn_ready), 8'd0);
    cyc();
    chk("full_live_refill", 8'(notes_live), 8'd4);

    // Hit window edges
    do_reset();
    do_spawn(4'b0001);
    ticks(399);
    do_strum(4'b0001, 4'b0000, 4'b0001);
    ticks(1);
    do_strum(4'b0001, 4'b0001, 4'b0000);
    cyc();
    chk("window_live_cleared", 8'(notes_live), 8'd0);
    do_spawn(4'b0001);
    ticks(449);
    do_strum(4'b0001, 4'b0001, 4'b0000);
    do_spawn(4'b0001);
    ticks(450);
    do_strum(4'b0001, 4'b0000, 4'b0001);
    cyc();
    chk("window_450_kept", 8'(notes_live), 8'd1);

    // Simultaneous tick and strum at the window edge
    do_reset();
    do_spawn(4'b0001);
    ticks(449);
    frame_tick = 1'b1;
    do_strum(4'b0001, 4'b0001, 4'b0000);
    cyc(); cyc();
    chk("simul_live", 8'(notes_live), 8'd0);

    // Spawn together with a tick: new note starts at y=0
    spawn_valid = 1'b1; spawn_mask = 4'b0001; frame_tick = 1'b1;
    cyc();
    spawn_valid = 1'b0;
    x = 10'd170; y = 9'd0;
    cyc();
    chk("spawn_tick_y0", 8'(pixel_in_note), 8'b0001);
    ticks(1);
    y = 9'd0;
    cyc();
    chk("spawn_tick_y1_top", 8'(pixel_in_note), 8'b0000);
    y = 9'd50;
    cyc();
    chk("spawn_tick_y1_bottom", 8'(pixel_in_note), 8'b0001);

    // Pixel test on lane 1
    do_reset();
    do_spawn(4'b0010);
    ticks(100);
    x = 10'd270; y = 9'd100; cyc();
    chk("pixel_270_100", 8'(pixel_in_note), 8'b0010);
    x = 10'd319; y = 9'd149; cyc();
    chk("pixel_319_149", 8'(pixel_in_note), 8'b0010);
    x = 10'd320; y = 9'd149; cyc();
    chk("pixel_320_149", 8'(pixel_in_note), 8'b0000);
    x = 10'd270; y = 9'd150; cyc();
    chk("pixel_270_150", 8'(pixel_in_note), 8'b0000);
    x = 10'd269; y = 9'd120; cyc();
    chk("pixel_269_120", 8'(pixel_in_note), 8'b0000);

    cyc(); cyc();
    chk("events_outstanding", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/note_lane_engine.md
# note_lane_engine

Parametrised note-scroller for the Guitar Hero display path. It holds up to SLOTS falling notes in each of LANES lanes and accepts new note rows through a valid/ready handshake. Every note advances by SPEED pixels per frame tick, and notes that leave the screen are retired as misses. Per-lane strum pulses are judged against a hit window. A registered per-lane "pixel inside a note" vector feeds the colour mux ahead of the VGA output.

## Interface
- LANES, 4, number of lanes (fret columns)
- SLOTS, 4, simultaneous notes per lane
- SCREEN_H, 480, visible height; a note whose top reaches this is retired
- NOTE_W, 50, square note edge in pixels
- SPEED, 1, pixels moved per frame_tick (1..NOTE_W)
- LANE_X0, 170, left x of lane 0
- LANE_PITCH, 100, x distance between lanes
- HIT_Y, 400, top of the hit window; window is [HIT_Y, HIT_Y+NOTE_W)
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, synchronous to clk
- spawn_valid  in  1  new note row offered
- spawn_mask  in  LANES  bit l set = note in lane l
- spawn_ready  out  LANES-independent 1  row can be accepted
- strum  in  LANES  one-cycle strum pulse per lane
- x  in  10  current scan x
- y  in  9  current scan y
- pixel_in_note  out  LANES  registered: (x,y) lies inside a live note of lane l
- hit  out  LANES  one-cycle pulse: strum matched a note, note removed
- miss  out  LANES  one-cycle pulse: note retired off-screen, or strum with no note in window
- notes_live  out  $clog2(LANES*SLOTS+1)  count of valid slots

## Operation
- Slot state per lane: valid bit and 10-bit unsigned top-y. Reset clears every valid bit and sets every y to 0.
- **Spawn**
  - spawn_ready = 1 when every lane set in spawn_mask has a free slot. The signal is combinational from the mask and slot state.
  - Transfer occurs on valid & ready. Each masked lane writes its lowest-index free slot with y=0 and valid=1.
  - A zero mask is accepted with no effect.
  - spawn_valid without ready has no effect; the offering side holds the row until ready.
- **Move**
  - On frame_tick every valid slot adds SPEED.
  - If the old y + SPEED ≥ SCREEN_H, the slot is cleared and miss[l] pulses. The sum is computed at 11 bits so it cannot wrap.
- **Strum**
  - strum[l] matches a valid slot with HIT_Y ≤ y < HIT_Y+NOTE_W.
  - With several matches, the lowest-index match is cleared and hit[l] pulses.
  - With no match, miss[l] pulses.
- **Simultaneous events in one cycle**
  - Strum is judged on the pre-move y. A slot cleared by the strum is not moved and does not also generate an exit miss.
  - A slot spawned this cycle is not moved until the next tick.
  - If an exit miss and a strum miss occur in the same lane, miss[l] is a single pulse.
  - Spawn sees the slot state before this cycle's clears, so freed slots become usable the following cycle.
- **Pixel test**: pixel_in_note[l] = OR over valid slots of:
  - LANE_X0 + l·LANE_PITCH ≤ x < that value + NOTE_W, and
  - y_slot ≤ y < y_slot + NOTE_W.
- notes_live is the registered population count of valid bits.

## Timing
- Reset (asynchronous assert) drives the following outputs:
  - pixel_in_note = 0, hit = 0, miss = 0, notes_live = 0.
  - spawn_ready = 1 while in reset, because all slots are free.
- Reset mid-frame discards all notes immediately. Operation resumes on the first clk edge after release.
- Spawn, move and strum effects are visible in slot state 1 cycle after the triggering edge.
- hit and miss are registered and asserted in the cycle after the event.
- pixel_in_note has 1-cycle latency from (x,y). The consumer compensates in its colour pipeline.
- notes_live lags slot state by 1 cycle.

## Structure
- The package note_lane_pkg holds:
  - default constants (LANES, SLOTS, geometry);
  - the function lane_x(l) = LANE_X0 + l·LANE_PITCH;
  - the slot struct {valid, y[9:0]}.
- Sub-module note_lane is instantiated LANES times. It owns the SLOTS slot registers and implements free-slot priority encoding, move/retire, strum judging and that lane's pixel test.
- The top level contains only:
  - the spawn_ready AND-reduction;
  - the generate loop of note_lane instances;
  - the notes_live population count.

## Test plan
- **Reset and spawn:** release reset, spawn mask 4'b0101 → slots 0 of lanes 0 and 2 valid at y=0, notes_live=2 two cycles later, spawn_ready stays 1.
- **Move and retire:** one note, 480 frame_ticks with SPEED=1 → miss[0] pulses once, in the cycle after the 480th tick; notes_live returns to 0.
- **Full lane:** 4 spawns with mask 4'b0001 and no ticks → spawn_ready=0 for mask 4'b0001, 1 for mask 4'b0010. A 5th row held valid stays pending; after lane 0 is freed by a strum hit, it is accepted on the next cycle.
- **Hit window:** note at y=399 → strum[0] → miss[0], note kept. Tick to y=400, strum → hit[0], note cleared. Another note at y=449 → hit; at y=450 → miss.
- **Simultaneous events:** at y=449, frame_tick and strum[0] in the same cycle → hit[0] only, no exit miss. Spawn in the same cycle as a tick → new note at y=0, then y=1 on the next tick.
- **Pixel:** note lane 1 at y=100, scan (270,100) → pixel_in_note=4'b0010 one cycle later. (319,149) → 1; (320,149) and (270,150) → 0.
